tfc_monitor: RTL and testbench
==============================

// Module: tfc_monitor
// PURPOSE
//  Receive-side checker for the 2-bit NS/EW traffic-light code interface (00 red, 01 yellow,
//  10 green). Samples both light codes every clock and decodes them into a phase. Flags
//  illegal codes, conflicting greens, out-of-order transitions, short green/yellow dwell and
//  stuck phases. Sits beside the light controller as a safety monitor; its outputs feed
//  status logic and testbench scoreboards.
// PARAMETERS
//  CNT_W      8    width of the dwell counter
//  MIN_GREEN  11   minimum cycles a green phase must be held before it is left
//  MIN_YELLOW 11   minimum cycles a yellow phase must be held before it is left
//  MAX_DWELL  255  dwell value that raises STUCK; must be <= 2**CNT_W-1 and > MIN_*
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  ns         in   2      north-south light code
//  ew         in   2      east-west light code
//  clr        in   1      clears sticky fault/err_code (1-cycle pulse)
//  phase      out  3      decoded phase: 0 INIT,1 NS_G,2 NS_Y,3 EW_G,4 EW_Y,5 ALL_R
//  dwell      out  CNT_W  consecutive cycles the current phase has been sampled, saturating
//  fault      out  1      sticky error flag
//  err_code   out  3      first error since clear: 0 none,1 ILL_CODE,2 CONFLICT,3 BAD_SEQ,
//                         4 SHORT_G,5 SHORT_Y,6 STUCK
//  cycle_cnt  out  16     completed NS->EW->NS cycles, wraps at 16'hFFFF->0
// BEHAVIOUR
//  - Reset (async, rst_n=0): phase=INIT, dwell=0, fault=0, err_code=0, cycle_cnt=0.
//  - All outputs are registered. An input applied before edge k is reflected after edge k.
//  - Decode of sample (ns,ew): (10,00) NS_G; (01,00) NS_Y; (00,10) EW_G; (00,01) EW_Y;
//    (00,00) ALL_R. If either code is 11, the result is ILL_CODE. If both codes are non-red,
//    the result is CONFLICT. ILL_CODE takes precedence over CONFLICT.
//  - Legal transitions: NS_G->NS_Y->EW_G->EW_Y->NS_G. Any legal phase may go to ALL_R.
//    ALL_R may go only to NS_G or EW_G. INIT may go to any legal phase with no checks.
//  - Same phase sampled again: dwell increments, saturating at MAX_DWELL. On the edge where
//    dwell reaches MAX_DWELL (in any phase except INIT), STUCK is raised once per phase
//    occupancy.
//  - Phase change: the new phase is loaded and dwell is set to 1. Checks on the old phase:
//    leaving a green with dwell<MIN_GREEN raises SHORT_G; leaving a yellow with
//    dwell<MIN_YELLOW raises SHORT_Y. ALL_R has no minimum.
//  - Error priority within one edge (lowest code wins): ILL_CODE > CONFLICT > BAD_SEQ >
//    SHORT_G/SHORT_Y > STUCK.
//  - ILL_CODE/CONFLICT sample: phase goes to INIT, dwell goes to 0. BAD_SEQ/SHORT: the new
//    phase is still adopted (resync) and dwell=1.
//  - fault/err_code are sticky and capture only the first error. Later errors do not
//    overwrite them while fault=1.
//  - clr=1 clears fault and err_code to 0. If clr and a new error occur on the same edge,
//    the new error is captured (fault=1, err_code=new).
//  - cycle_cnt increments on each legal EW_Y->NS_G transition, including one that is also
//    SHORT_Y.
//  - Reset asserted mid-operation returns every output to its reset value immediately. The
//    first sample after reset is an INIT exit and is never flagged except ILL_CODE/CONFLICT.
// TESTING
//  1 Reset: drive rst_n=0 mid-run -> phase=0, dwell=0, fault=0, err_code=0, cycle_cnt=0
//    asynchronously.
//  2 Nominal: NS_G,NS_Y,EW_G,EW_Y each held 11 cycles, repeated 3 times -> fault stays 0;
//    cycle_cnt=1 one edge after the first EW_Y->NS_G, and 2 after the second; dwell peaks
//    at 11.
//  3 Conflict: ns=10, ew=10 for 1 cycle -> next edge fault=1, err_code=2, phase=0. Then a
//    BAD_SEQ -> err_code stays 2.
//  4 Sequence/timing: NS_G 11 cycles then EW_G -> err_code=3, phase=3. After clr, NS_G
//    5 cycles then NS_Y -> err_code=4.
//  5 Stuck/illegal: hold NS_G 255 cycles -> err_code=6 on the edge dwell=255, and dwell
//    stays 255. After clr, ns=11 -> err_code=1.
//  6 Clear race: clr pulsed on the same edge as a SHORT_Y exit -> fault=1, err_code=5.

Source files
------------

// File: rtl/tfc_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tfc_monitor
// Purpose  : Receive-side safety monitor for a two-road traffic-light
//            controller. It samples the NS/EW 2-bit light codes
//            (00 red, 01 yellow, 10 green) every clock and decodes them
//            into a phase. It flags illegal codes, conflicting greens,
//            out-of-order transitions, short green/yellow dwell and stuck
//            phases. The first error since the last clear is held sticky.
// Ports    : clk        in   rising-edge clock
//            rst_n      in   asynchronous active-low reset
//            ns, ew     in   north-south / east-west light codes
//            clr        in   clears sticky fault / err_code
//            phase      out  decoded phase (0 INIT,1 NS_G,2 NS_Y,3 EW_G,
//                            4 EW_Y,5 ALL_R)
//            dwell      out  consecutive samples of current phase (saturating)
//            fault      out  sticky error flag
//            err_code   out  first error since clear (0 none,1 ILL_CODE,
//                            2 CONFLICT,3 BAD_SEQ,4 SHORT_G,5 SHORT_Y,6 STUCK)
//            cycle_cnt  out  completed NS->EW->NS cycles (wrapping)
// Revision : 1.0  initial release
// ============================================================================
module tfc_monitor #(
  parameter int CNT_W      = 8,
  parameter int MIN_GREEN  = 11,
  parameter int MIN_YELLOW = 11,
  parameter int MAX_DWELL  = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       ns,
  input  logic [1:0]       ew,
  input  logic             clr,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] dwell,
  output logic             fault,
  output logic [2:0]       err_code,
  output logic [15:0]      cycle_cnt
);

  // Phase encoding
  localparam logic [2:0] PH_INIT  = 3'd0;
  localparam logic [2:0] PH_NS_G  = 3'd1;
  localparam logic [2:0] PH_NS_Y  = 3'd2;
  localparam logic [2:0] PH_EW_G  = 3'd3;
  localparam logic [2:0] PH_EW_Y  = 3'd4;
  localparam logic [2:0] PH_ALL_R = 3'd5;

  // Error encoding (lower value = higher priority)
  localparam logic [2:0] E_NONE     = 3'd0;
  localparam logic [2:0] E_ILL_CODE = 3'd1;
  localparam logic [2:0] E_CONFLICT = 3'd2;
  localparam logic [2:0] E_BAD_SEQ  = 3'd3;
  localparam logic [2:0] E_SHORT_G  = 3'd4;
  localparam logic [2:0] E_SHORT_Y  = 3'd5;
  localparam logic [2:0] E_STUCK    = 3'd6;

  localparam logic [CNT_W-1:0] C_MAX_DWELL  = CNT_W'(MAX_DWELL);
  localparam logic [CNT_W-1:0] C_STUCK_PRE  = CNT_W'(MAX_DWELL - 1);
  localparam logic [CNT_W-1:0] C_MIN_GREEN  = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] C_MIN_YELLOW = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);

  logic [2:0] w_dec;
  logic       w_ill;
  logic       w_conf;
  logic       w_valid;
  logic       w_same;
  logic       w_change;
  logic       w_legal;
  logic       w_bad_seq;
  logic       w_short_g;
  logic       w_short_y;
  logic       w_stuck;
  logic       w_cycle_done;
  logic [2:0] w_err;

  // Sample decode and per-edge error detection
  always_comb begin
    w_ill  = (ns == 2'b11) || (ew == 2'b11);
    // An illegal code masks the conflict check
    w_conf = !w_ill && (ns != 2'b00) && (ew != 2'b00);

    w_dec = PH_INIT;
    case ({ns, ew})
      4'b1000: w_dec = PH_NS_G;
      4'b0100: w_dec = PH_NS_Y;
      4'b0010: w_dec = PH_EW_G;
      4'b0001: w_dec = PH_EW_Y;
      4'b0000: w_dec = PH_ALL_R;
      default: w_dec = PH_INIT;
    endcase

    w_valid  = !w_ill && !w_conf;
    w_same   = w_valid && (w_dec == phase);
    w_change = w_valid && (w_dec != phase);

    // Allowed successor of the current phase; INIT accepts anything
    w_legal = 1'b1;
    case (phase)
      PH_NS_G:  w_legal = (w_dec == PH_NS_Y) || (w_dec == PH_ALL_R);
      PH_NS_Y:  w_legal = (w_dec == PH_EW_G) || (w_dec == PH_ALL_R);
      PH_EW_G:  w_legal = (w_dec == PH_EW_Y) || (w_dec == PH_ALL_R);
      PH_EW_Y:  w_legal = (w_dec == PH_NS_G) || (w_dec == PH_ALL_R);
      PH_ALL_R: w_legal = (w_dec == PH_NS_G) || (w_dec == PH_EW_G);
      default:  w_legal = 1'b1;
    endcase

    w_bad_seq = w_change && !w_legal;
    w_short_g = w_change && ((phase == PH_NS_G) || (phase == PH_EW_G))
                && (dwell < C_MIN_GREEN);
    w_short_y = w_change && ((phase == PH_NS_Y) || (phase == PH_EW_Y))
                && (dwell < C_MIN_YELLOW);
    // Fires only on the edge where dwell steps onto the saturation value,
    // so it is raised once per phase occupancy.
    w_stuck   = w_same && (phase != PH_INIT) && (dwell == C_STUCK_PRE);

    w_cycle_done = w_change && (phase == PH_EW_Y) && (w_dec == PH_NS_G);

    if (w_ill)          w_err = E_ILL_CODE;
    else if (w_conf)    w_err = E_CONFLICT;
    else if (w_bad_seq) w_err = E_BAD_SEQ;
    else if (w_short_g) w_err = E_SHORT_G;
    else if (w_short_y) w_err = E_SHORT_Y;
    else if (w_stuck)   w_err = E_STUCK;
    else                w_err = E_NONE;
  end

  // Phase tracking and dwell counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= PH_INIT;
      dwell <= '0;
    end else if (!w_valid) begin
      phase <= PH_INIT;
      dwell <= '0;
    end else if (w_same) begin
      if (dwell != C_MAX_DWELL) dwell <= dwell + C_ONE;
    end else begin
      // Also taken on BAD_SEQ / SHORT: resync to the observed phase
      phase <= w_dec;
      dwell <= C_ONE;
    end
  end

  // Sticky first-error capture; a new error on a clear edge wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault    <= 1'b0;
      err_code <= E_NONE;
    end else if (clr) begin
      fault    <= (w_err != E_NONE);
      err_code <= w_err;
    end else if (!fault && (w_err != E_NONE)) begin
      fault    <= 1'b1;
      err_code <= w_err;
    end
  end

  // Completed-cycle counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
    end else if (w_cycle_done) begin
      cycle_cnt <= cycle_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tfc_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_tfc_monitor
// Purpose  : Directed self-checking bench for tfc_monitor.
// Revision : 1.0  initial release
// ============================================================================
module tb_tfc_monitor;

  logic        clk;
  logic        rst_n;
  logic [1:0]  ns;
  logic [1:0]  ew;
  logic        clr;
  logic [2:0]  phase;
  logic [7:0]  dwell;
  logic        fault;
  logic [2:0]  err_code;
  logic [15:0] cycle_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  tfc_monitor #(
    .CNT_W      (8),
    .MIN_GREEN  (11),
    .MIN_YELLOW (11),
    .MAX_DWELL  (255)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ns        (ns),
    .ew        (ew),
    .clr       (clr),
    .phase     (phase),
    .dwell     (dwell),
    .fault     (fault),
    .err_code  (err_code),
    .cycle_cnt (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Apply one sample, let one rising edge take it, settle 1 time unit after.
  task automatic step(input logic [1:0] n, input logic [1:0] e, input logic c);
    ns  = n;
    ew  = e;
    clr = c;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic hold(input logic [1:0] n, input logic [1:0] e, input int cycles);
    for (int i = 0; i < cycles; i++) step(n, e, 1'b0);
  endtask

  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] G = 2'b10;

  initial begin
    rst_n = 1'b0;
    ns    = R;
    ew    = R;
    clr   = 1'b0;
    #12;
    chk("rst_phase", 16'(phase), 16'd0);
    chk("rst_dwell", 16'(dwell), 16'd0);
    chk("rst_fault", 16'(fault), 16'd0);
    chk("rst_err", 16'(err_code), 16'd0);
    chk("rst_cyc", cycle_cnt, 16'd0);
    rst_n = 1'b1;

    // Nominal: three full rounds, 11 cycles each phase
    for (int r = 0; r < 3; r++) begin
      step(G, R, 1'b0);
      if (r == 1) chk("nom_cyc1", cycle_cnt, 16'd1);
      if (r == 2) chk("nom_cyc2", cycle_cnt, 16'd2);
      hold(G, R, 10);
      if (r == 0) begin
        chk("nom_ph_nsg", 16'(phase), 16'd1);
        chk("nom_dwell11", 16'(dwell), 16'd11);
      end
      hold(Y, R, 11);
      hold(R, G, 11);
      hold(R, Y, 11);
    end
    chk("nom_fault", 16'(fault), 16'd0);
    chk("nom_ph_ewy", 16'(phase), 16'd4);
    chk("nom_dwell_end", 16'(dwell), 16'd11);
    chk("nom_cyc_end", cycle_cnt, 16'd2);

    // Conflict, then a BAD_SEQ that must not overwrite it
    step(G, G, 1'b0);
    chk("conf_fault", 16'(fault), 16'd1);
    chk("conf_err", 16'(err_code), 16'd2);
    chk("conf_phase", 16'(phase), 16'd0);
    chk("conf_dwell", 16'(dwell), 16'd0);
    step(G, R, 1'b0);                  // INIT exit, unchecked
    step(R, G, 1'b0);                  // NS_G -> EW_G : BAD_SEQ
    chk("conf_sticky", 16'(err_code), 16'd2);
    chk("conf_resync", 16'(phase), 16'd3);
    step(R, R, 1'b0);                  // go ALL_R (short green, still sticky)
    step(R, R, 1'b1);                  // clear with no new error
    chk("clr_fault", 16'(fault), 16'd0);
    chk("clr_err", 16'(err_code), 16'd0);

    // Sequence: NS_G held 11 then EW_G
    hold(G, R, 11);
    step(R, G, 1'b0);
    chk("seq_err", 16'(err_code), 16'd3);
    chk("seq_phase", 16'(phase), 16'd3);
    chk("seq_dwell", 16'(dwell), 16'd1);
    step(R, G, 1'b1);                  // clear, EW_G dwell 2
    hold(R, G, 9);                     // EW_G dwell 11
    step(R, R, 1'b0);                  // legal exit to ALL_R
    chk("seq_clean", 16'(fault), 16'd0);

    // Short green: NS_G 5 cycles then NS_Y
    hold(G, R, 5);
    step(Y, R, 1'b0);
    chk("shortg_err", 16'(err_code), 16'd4);
    chk("shortg_fault", 16'(fault), 16'd1);
    step(Y, R, 1'b1);                  // clear, NS_Y dwell 2
    hold(Y, R, 9);                     // NS_Y dwell 11
    step(R, R, 1'b0);                  // legal exit to ALL_R

    // Stuck: NS_G held 255 cycles
    hold(G, R, 254);
    chk("stuck_pre_fault", 16'(fault), 16'd0);
    chk("stuck_pre_dwell", 16'(dwell), 16'd254);
    step(G, R, 1'b0);
    chk("stuck_dwell", 16'(dwell), 16'd255);
    chk("stuck_err", 16'(err_code), 16'd6);
    step(G, R, 1'b0);
    chk("stuck_sat", 16'(dwell), 16'd255);
    step(G, R, 1'b1);                  // clear; saturated dwell raises nothing new
    chk("stuck_once", 16'(fault), 16'd0);
    step(2'b11, R, 1'b0);
    chk("ill_err", 16'(err_code), 16'd1);
    chk("ill_phase", 16'(phase), 16'd0);
    chk("ill_dwell", 16'(dwell), 16'd0);

    // Clear race on a short EW_Y -> NS_G exit (still counts a cycle)
    hold(R, Y, 3);                     // INIT -> EW_Y, unchecked
    step(G, R, 1'b1);
    chk("race_fault", 16'(fault), 16'd1);
    chk("race_err", 16'(err_code), 16'd5);
    chk("race_cyc", cycle_cnt, 16'd3);

    // Asynchronous reset mid-run
    hold(G, R, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_phase", 16'(phase), 16'd0);
    chk("arst_dwell", 16'(dwell), 16'd0);
    chk("arst_fault", 16'(fault), 16'd0);
    chk("arst_err", 16'(err_code), 16'd0);
    chk("arst_cyc", cycle_cnt, 16'd0);
    rst_n = 1'b1;
    step(R, Y, 1'b0);                  // first sample after reset: INIT exit
    chk("post_phase", 16'(phase), 16'd4);
    chk("post_fault", 16'(fault), 16'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
